// File: rtl/dual_port_ram_sync.sv
// Synchronous true dual-port RAM with registered reads, optional output
// register, write-write collision flag and a sequential clear after reset.
module dual_port_ram_sync #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned READ_MODE      = 0,
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic [DATA_WIDTH-1:0] data_in_a,
  input  logic                  write_enable_a,
  input  logic                  read_enable_a,
  output logic [DATA_WIDTH-1:0] data_out_a,
  output logic                  valid_a,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic [DATA_WIDTH-1:0] data_in_b,
  input  logic                  write_enable_b,
  input  logic                  read_enable_b,
  output logic [DATA_WIDTH-1:0] data_out_b,
  output logic                  valid_b,
  output logic                  collision,
  output logic                  busy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_busy;
  logic                  r_collision;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [DATA_WIDTH-1:0] r_s1_data_a;
  logic [DATA_WIDTH-1:0] r_s1_data_b;
  logic                  r_s1_vld_a;
  logic                  r_s1_vld_b;

  logic                  w_run;
  logic                  w_clr;
  logic                  w_we_a;
  logic                  w_we_b;
  logic                  w_re_a;
  logic                  w_re_b;
  logic [DATA_WIDTH-1:0] w_rd_a;
  logic [DATA_WIDTH-1:0] w_rd_b;

  // Port requests only count in RUN; reset cycles never touch the array
  assign w_run  = (r_state == ST_RUN) && !rst;
  assign w_clr  = (r_state == ST_CLEAR) && !rst;
  assign w_we_a = w_run && write_enable_a;
  assign w_we_b = w_run && write_enable_b;
  assign w_re_a = w_run && read_enable_a;
  assign w_re_b = w_run && read_enable_b;

  // Same-port write-first bypasses the array; cross-port always sees the old word
  assign w_rd_a = ((READ_MODE != 0) && w_we_a) ? data_in_a : r_mem[address_a];
  assign w_rd_b = ((READ_MODE != 0) && w_we_b) ? data_in_b : r_mem[address_b];

  // Clear/run state machine with clear counter and busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      r_busy  <= (CLEAR_ON_RESET != 0);
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_cnt <= r_cnt + ADDR_WIDTH'(1);
          if (r_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          r_busy <= 1'b0;
        end
        default: begin
          r_state <= ST_RUN;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage: clear writes, else port writes with A taking priority on a shared address
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_mem[r_cnt] <= '0;
    end else begin
      if (w_we_b) begin
        r_mem[address_b] <= data_in_b;
      end
      if (w_we_a) begin
        r_mem[address_a] <= data_in_a;
      end
    end
  end

  // First read stage and collision pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_data_a <= '0;
      r_s1_data_b <= '0;
      r_s1_vld_a  <= 1'b0;
      r_s1_vld_b  <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      r_s1_vld_a  <= w_re_a;
      r_s1_vld_b  <= w_re_b;
      r_collision <= w_we_a && w_we_b && (address_a == address_b);
      if (w_re_a) begin
        r_s1_data_a <= w_rd_a;
      end
      if (w_re_b) begin
        r_s1_data_b <= w_rd_b;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : gen_out_reg
      logic [DATA_WIDTH-1:0] r_out_data_a;
      logic [DATA_WIDTH-1:0] r_out_data_b;
      logic                  r_out_vld_a;
      logic                  r_out_vld_b;

      // Extra output stage; data holds between reads
      always_ff @(posedge clk) begin
        if (rst) begin
          r_out_data_a <= '0;
          r_out_data_b <= '0;
          r_out_vld_a  <= 1'b0;
          r_out_vld_b  <= 1'b0;
        end else begin
          r_out_vld_a <= r_s1_vld_a;
          r_out_vld_b <= r_s1_vld_b;
          if (r_s1_vld_a) begin
            r_out_data_a <= r_s1_data_a;
          end
          if (r_s1_vld_b) begin
            r_out_data_b <= r_s1_data_b;
          end
        end
      end

      assign data_out_a = r_out_data_a;
      assign data_out_b = r_out_data_b;
      assign valid_a    = r_out_vld_a;
      assign valid_b    = r_out_vld_b;
    end else begin : gen_no_out_reg
      assign data_out_a = r_s1_data_a;
      assign data_out_b = r_s1_data_b;
      assign valid_a    = r_s1_vld_a;
      assign valid_b    = r_s1_vld_b;
    end
  endgenerate

  assign collision = r_collision;
  assign busy      = r_busy;

endmodule

// File: tb/tb_dual_port_ram_sync.sv
// Directed bench: three configurations share one stimulus stream.
//   d0: read-first, 1-cycle latency, clear on reset
//   d1: write-first, 2-cycle latency, clear on reset
//   d2: read-first, 1-cycle latency, no clear
module tb_dual_port_ram_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] address_a, address_b;
  logic [7:0] data_in_a, data_in_b;
  logic       write_enable_a, write_enable_b;
  logic       read_enable_a, read_enable_b;

  logic [7:0] d0_out_a, d0_out_b, d1_out_a, d1_out_b, d2_out_a, d2_out_b;
  logic       d0_vld_a, d0_vld_b, d1_vld_a, d1_vld_b, d2_vld_a, d2_vld_b;
  logic       d0_col, d1_col, d2_col;
  logic       d0_busy, d1_busy, d2_busy;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  dual_port_ram_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_MODE(0), .OUT_REG(0),
                       .CLEAR_ON_RESET(1)) u_d0 (
    .clk(clk), .rst(rst),
    .address_a(address_a), .data_in_a(data_in_a), .write_enable_a(write_enable_a),
    .read_enable_a(read_enable_a), .data_out_a(d0_out_a), .valid_a(d0_vld_a),
    .address_b(address_b), .data_in_b(data_in_b), .write_enable_b(write_enable_b),
    .read_enable_b(read_enable_b), .data_out_b(d0_out_b), .valid_b(d0_vld_b),
    .collision(d0_col), .busy(d0_busy));

  dual_port_ram_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_MODE(1), .OUT_REG(1),
                       .CLEAR_ON_RESET(1)) u_d1 (
    .clk(clk), .rst(rst),
    .address_a(address_a), .data_in_a(data_in_a), .write_enable_a(write_enable_a),
    .read_enable_a(read_enable_a), .data_out_a(d1_out_a), .valid_a(d1_vld_a),
    .address_b(address_b), .data_in_b(data_in_b), .write_enable_b(write_enable_b),
    .read_enable_b(read_enable_b), .data_out_b(d1_out_b), .valid_b(d1_vld_b),
    .collision(d1_col), .busy(d1_busy));

  dual_port_ram_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_MODE(0), .OUT_REG(0),
                       .CLEAR_ON_RESET(0)) u_d2 (
    .clk(clk), .rst(rst),
    .address_a(address_a), .data_in_a(data_in_a), .write_enable_a(write_enable_a),
    .read_enable_a(read_enable_a), .data_out_a(d2_out_a), .valid_a(d2_vld_a),
    .address_b(address_b), .data_in_b(data_in_b), .write_enable_b(write_enable_b),
    .read_enable_b(read_enable_b), .data_out_b(d2_out_b), .valid_b(d2_vld_b),
    .collision(d2_col), .busy(d2_busy));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_enable_a = 1'b0; write_enable_b = 1'b0;
    read_enable_a  = 1'b0; read_enable_b  = 1'b0;
    address_a = 4'd0; address_b = 4'd0;
    data_in_a = 8'd0; data_in_b = 8'd0;
  endtask

  initial begin
    logic [3:0] burst_addr [4];
    logic [7:0] burst_data [4];
    burst_addr = '{4'd2, 4'd3, 4'd5, 4'd7};
    burst_data = '{8'hAA, 8'h55, 8'h22, 8'h0F};

    // Reset and clear
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_busy0", 32'(d0_busy), 32'd1);
    check("rst_out_a0", 32'(d0_out_a), 32'h00);
    check("rst_vld_a0", 32'(d0_vld_a), 32'd0);
    check("rst_col0", 32'(d0_col), 32'd0);
    check("rst_out_b1", 32'(d1_out_b), 32'h00);
    check("rst_busy2", 32'(d2_busy), 32'd0);

    // Write during busy: ignored by d0/d1, taken by d2
    address_a = 4'd4; data_in_a = 8'hEE; write_enable_a = 1'b1;
    step();
    idle();
    n = 1;
    while (d0_busy && n < 40) begin
      n++;
      step();
    end
    // Reset cycle plus 16 clear cycles
    check("busy_len", 32'(1 + n), 32'd17);

    // Read back every address on port A
    for (int i = 0; i <= 16; i++) begin
      idle();
      if (i < 16) begin
        read_enable_a = 1'b1;
        address_a = 4'(i);
      end
      step();
      if (i < 16) begin
        check("clr_d0", 32'(d0_out_a), 32'h00);
        check("clr_v0", 32'(d0_vld_a), 32'd1);
        if (i == 4) check("d2_wr_in_busy", 32'(d2_out_a), 32'hEE);
      end else begin
        check("clr_v0_end", 32'(d0_vld_a), 32'd0);
      end
      if (i > 0) begin
        check("clr_d1", 32'(d1_out_a), 32'h00);
        check("clr_v1", 32'(d1_vld_a), 32'd1);
      end
    end
    idle();

    // Basic two-port write then cross read
    write_enable_a = 1'b1; address_a = 4'd2; data_in_a = 8'hAA;
    write_enable_b = 1'b1; address_b = 4'd3; data_in_b = 8'h55;
    step();
    check("wr_no_vld", 32'(d0_vld_a), 32'd0);
    check("wr_no_col", 32'(d0_col), 32'd0);
    idle();
    read_enable_a = 1'b1; address_a = 4'd3;
    read_enable_b = 1'b1; address_b = 4'd2;
    step();
    check("basic_a0", 32'(d0_out_a), 32'h55);
    check("basic_b0", 32'(d0_out_b), 32'hAA);
    check("basic_va0", 32'(d0_vld_a), 32'd1);
    check("basic_vb0", 32'(d0_vld_b), 32'd1);
    check("basic_col0", 32'(d0_col), 32'd0);
    check("basic_a2", 32'(d2_out_a), 32'h55);
    check("basic_v1_early", 32'(d1_vld_a), 32'd0);
    idle();
    step();
    check("basic_a1", 32'(d1_out_a), 32'h55);
    check("basic_b1", 32'(d1_out_b), 32'hAA);
    check("basic_va1", 32'(d1_vld_a), 32'd1);
    check("hold_v0", 32'(d0_vld_a), 32'd0);
    check("hold_a0", 32'(d0_out_a), 32'h55);

    // Same-port read during write
    write_enable_a = 1'b1; address_a = 4'd5; data_in_a = 8'h11;
    step();
    data_in_a = 8'h22; read_enable_a = 1'b1;
    step();
    check("rw_old_d0", 32'(d0_out_a), 32'h11);
    check("rw_vld_d0", 32'(d0_vld_a), 32'd1);
    idle();
    step();
    check("rw_new_d1", 32'(d1_out_a), 32'h22);
    check("rw_vld_d1", 32'(d1_vld_a), 32'd1);
    read_enable_a = 1'b1; address_a = 4'd5;
    step();
    check("rw_reread_d0", 32'(d0_out_a), 32'h22);
    idle();
    step();
    check("rw_reread_d1", 32'(d1_out_a), 32'h22);

    // Write-write collision on one address
    write_enable_a = 1'b1; address_a = 4'd7; data_in_a = 8'h0F;
    write_enable_b = 1'b1; address_b = 4'd7; data_in_b = 8'hF0;
    step();
    check("col_d0", 32'(d0_col), 32'd1);
    check("col_d1", 32'(d1_col), 32'd1);
    idle();
    step();
    check("col_pulse_d0", 32'(d0_col), 32'd0);
    read_enable_a = 1'b1; address_a = 4'd7;
    read_enable_b = 1'b1; address_b = 4'd7;
    step();
    check("col_rd_a0", 32'(d0_out_a), 32'h0F);
    check("col_rd_b0", 32'(d0_out_b), 32'h0F);
    idle();
    step();
    check("col_rd_b1", 32'(d1_out_b), 32'h0F);

    // Cross-port read during write
    write_enable_a = 1'b1; address_a = 4'd9; data_in_a = 8'h33;
    read_enable_b = 1'b1; address_b = 4'd9;
    step();
    check("xp_old_d0", 32'(d0_out_b), 32'h00);
    idle();
    read_enable_b = 1'b1; address_b = 4'd9;
    step();
    check("xp_new_d0", 32'(d0_out_b), 32'h33);
    check("xp_old_d1", 32'(d1_out_b), 32'h00);
    idle();
    step();
    check("xp_new_d1", 32'(d1_out_b), 32'h33);

    // Output-register latency: single read
    read_enable_a = 1'b1; address_a = 4'd2;
    step();
    check("or1_n", 32'(d1_vld_a), 32'd0);
    idle();
    step();
    check("or1_n1_v", 32'(d1_vld_a), 32'd1);
    check("or1_n1_d", 32'(d1_out_a), 32'hAA);
    step();
    check("or1_n2_v", 32'(d1_vld_a), 32'd0);

    // Output-register latency: four back-to-back reads
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i < 4) begin
        read_enable_a = 1'b1;
        address_a = burst_addr[i];
      end
      step();
      if (i >= 1 && i <= 4) begin
        check("burst_v", 32'(d1_vld_a), 32'd1);
        check("burst_d", 32'(d1_out_a), 32'(burst_data[i-1]));
      end else begin
        check("burst_idle", 32'(d1_vld_a), 32'd0);
      end
    end
    idle();

    // Reset in the middle of a clear restarts it
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_busy2", 32'(d2_busy), 32'd0);
    for (int k = 0; k < 8; k++) step();
    check("mid_busy", 32'(d0_busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n = 0;
    while (d0_busy && n < 40) begin
      n++;
      step();
    end
    check("restart_len", 32'(n), 32'd16);
    read_enable_a = 1'b1; address_a = 4'd2;
    step();
    check("restart_rd", 32'(d0_out_a), 32'h00);
    check("restart_vld", 32'(d0_vld_a), 32'd1);
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dual_port_ram_sync.md
Name: dual_port_ram_sync

Overview:
Parameterised, clocked true dual-port RAM and the successor to the combinational dual_port_ram. Two independent read/write ports share one storage array. Each port has registered reads with a valid strobe and a selectable read-during-write mode. Adds an optional output pipeline stage, write-write collision detection, and a sequential memory clear after reset. Used as the generic shared buffer between two producer/consumer engines on one clock.

Parameters:
DATA_WIDTH, 8, word width in bits
ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words
READ_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data)
OUT_REG, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency
CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = contents untouched by reset

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  reset; synchronous, active-high
address_a  input  ADDR_WIDTH  port A address
data_in_a  input  DATA_WIDTH  port A write data
write_enable_a  input  1  port A write request
read_enable_a  input  1  port A read request
data_out_a  output  DATA_WIDTH  port A read data
valid_a  output  1  data_out_a holds the result of a read issued on port A
address_b, data_in_b, write_enable_b, read_enable_b  inputs  as port A  port B request
data_out_b  output  DATA_WIDTH  port B read data
valid_b  output  1  port B read valid
collision  output  1  one-cycle pulse: both ports wrote the same address
busy  output  1  clear in progress; all port requests are ignored

Behaviour:
- Reset (rst high at a clock edge): data_out_a/b = 0, valid_a/b = 0, collision = 0, pipeline registers cleared.
  - CLEAR_ON_RESET=1: busy = 1 and the state goes to CLEAR, with the clear counter at 0.
  - CLEAR_ON_RESET=0: busy = 0 and the state goes to RUN.
- State machine, two states:
  - CLEAR: each cycle writes 0 to address cnt, then increments cnt. After address DEPTH-1 is written, the next state is RUN and busy drops.
  - Busy therefore reads 1 for the reset cycle plus DEPTH cycles.
  - RUN: normal operation.
- Reset asserted mid-CLEAR restarts the clear at cnt = 0.
- While busy:
  - write_enable_* and read_enable_* are ignored.
  - No memory update from the ports and no valid pulses.
- Read: read_enable_x sampled at edge n.
  - OUT_REG=0: data_out_x and valid_x update at edge n+1.
  - OUT_REG=1: they update at edge n+2.
  - valid_x is high exactly one cycle per read, aligned with its data.
- Output hold: with no read, valid_x = 0 and data_out_x holds its last value.
- Write: the memory updates at the edge where write_enable_x is sampled. A write without a read produces no valid.
- Same-port read and write in one cycle: the write is performed. The read returns the old word (READ_MODE=0) or data_in_x (READ_MODE=1).
- Cross-port, one port writes address X while the other reads X in the same cycle:
  - The reader always gets the old word, independent of READ_MODE.
  - A read issued the following cycle gets the new word.
- Both ports write the same address in the same cycle:
  - Port A's data is stored.
  - collision = 1 for exactly one cycle at the next edge (the same edge as a 1-cycle read result).
- Writes to different addresses in the same cycle both take effect, with no collision.
- Back-to-back reads are fully pipelined: one result per cycle per port.
- Addresses are ADDR_WIDTH wide with no out-of-range case. The clear counter wraps only by leaving CLEAR.

Test Plan:
1. Clear: CLEAR_ON_RESET=1, rst high 1 cycle -> busy high for 17 cycles. Afterwards, reading all 16 addresses on A returns 0x00 each with valid_a. A write request during busy (0xEE to addr 4) is ignored, and addr 4 later reads 0x00.
2. Basic: A writes 0xAA to addr 2 and B writes 0x55 to addr 3 in the same cycle. Next cycle A reads 3 and B reads 2 -> one cycle later data_out_a = 0x55, data_out_b = 0xAA, valid_a = valid_b = 1, collision = 0.
3. Same-port RW: addr 5 holds 0x11; A writes 0x22 to addr 5 with read_enable_a = 1.
   - READ_MODE=0 -> data_out_a = 0x11.
   - READ_MODE=1 -> data_out_a = 0x22.
   - A re-read returns 0x22 in both modes.
4. Collision: A writes 0x0F and B writes 0xF0 to addr 7 in the same cycle -> collision = 1 for one cycle. A later read of addr 7 on either port returns 0x0F.
5. Cross-port: addr 9 = 0x00; A writes 0x33 to addr 9 while B reads addr 9 -> data_out_b = 0x00. B's read the next cycle -> 0x33.
6. OUT_REG=1 and reset mid-clear:
   - A read issued at edge n -> valid_a at n+2 only.
   - 4 consecutive reads -> 4 consecutive valid cycles.
   - rst asserted when cnt = 8 -> busy stays high, then 16 more cycles.
